arb_client: RTL

Requester-side agent for the three-way fixed-priority grant arbiter. It queues transfer commands from local logic in a small FIFO, raises `req` toward its arbiter input, streams the commanded number of beats while `gnt` is held, and then releases `req`. It waits for `gnt` to fall before it requests again. One instance sits on each of the arbiter's `r[i]`/`g[i]` pairs.

---
 rtl/arb_client.sv | 113 +++++++++++
 1 files changed

// File: rtl/arb_client.sv
// Requester-side agent for the fixed-priority grant arbiter: queues transfer
// commands, requests the bus, streams the commanded beats, then releases.
module arb_client #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cmd_valid,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             cmd_ready,
  output logic             req,
  input  logic             gnt,
  output logic             beat_valid,
  output logic [LEN_W-1:0] beat_idx,
  output logic             beat_last,
  output logic             busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;
  localparam logic [1:0] ST_REL  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [LEN_W-1:0] beat_idx_q, beat_idx_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] mem_q [DEPTH];
  logic [LEN_W-1:0] mem_d [DEPTH];

  logic             push;
  logic             pop;
  logic [LEN_W-1:0] head_len;

  assign cmd_ready  = (cnt_q != CNT_W'(DEPTH));
  assign push       = cmd_valid && cmd_ready;
  assign head_len   = mem_q[rd_ptr_q];
  assign beat_valid = (state_q == ST_XFER) && gnt;
  assign beat_last  = beat_valid && (beat_idx_q == head_len);
  assign pop        = beat_last;
  assign beat_idx   = beat_idx_q;
  assign req        = (state_q == ST_REQ) || (state_q == ST_XFER);
  assign busy       = (state_q != ST_IDLE) || (cnt_q != '0);

  always_comb begin
    state_d    = state_q;
    beat_idx_d = beat_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (cnt_q != '0) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (gnt) begin
          state_d    = ST_XFER;
          beat_idx_d = '0;
        end
      end
      ST_XFER: begin
        if (beat_last) begin
          state_d = ST_REL;
        end else if (beat_valid) begin
          beat_idx_d = beat_idx_q + LEN_W'(1);
        end
      end
      ST_REL: begin
        // The arbiter keeps gnt one cycle past req falling; wait it out.
        if (!gnt) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = cmd_len;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      beat_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      beat_idx_q <= beat_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      mem_q      <= mem_d;
    end
  end

endmodule
